// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO. The data width, parity mode and stop-bit
// count are configurable. Frames leave back-to-back on TX while the FIFO holds words.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 2605,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_ovf
);

    localparam int FRAME_LEN = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BAUD_W    = $clog2(CLK_DIV);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic                   push, pop;

    // The whole frame is built at load time, start bit in bit 0. The shifter fills with 1s,
    // so it is all-ones (line idle) once every bit has been shifted out.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_BITS-1:0] d);
        logic [FRAME_LEN-1:0] f;
        f               = '1;
        f[0]            = 1'b0;
        f[DATA_BITS:1]  = d;
        if (PARITY != 0) f[DATA_BITS+1] = (PARITY == 2) ? ~(^d) : ^d;
        return f;
    endfunction

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        done_d   = 1'b0;
        ovf_d    = trmt && full_q;
        push     = trmt && !full_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = build_frame(mem[rd_ptr_q]);
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[FRAME_LEN-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == BIT_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Reload on the same edge so the next start bit directly follows the stop bit.
                        if (!empty_q) begin
                            pop     = 1'b1;
                            shift_d = build_frame(mem[rd_ptr_q]);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: only words counted in count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    assign TX       = shift_q[0];
    assign tx_busy  = (state_q == SHIFT);
    assign tx_done  = done_q;
    assign tx_full  = full_q;
    assign tx_empty = empty_q;
    assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo. Three instances cover 8N1, even parity and odd parity
// with two stop bits. Per-instance monitors decode the TX frames and check them against queued expectations.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a = 1'b0, rst_n_bc = 1'b0;
    logic [2:0] trmt = '0;
    logic [7:0] data_a = '0, data_b = '0, data_c = '0;
    wire  [2:0] tx_w, busy_w, done_w, full_w, empty_w, ovf_w;
    wire  [2:0] rst_w = {rst_n_bc, rst_n_bc, rst_n_a};

    uart_tx_fifo #(.CLK_DIV(16)) u_a (
        .clk(clk), .rst_n(rst_n_a), .trmt(trmt[0]), .tx_data(data_a), .TX(tx_w[0]),
        .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_full(full_w[0]),
        .tx_empty(empty_w[0]), .tx_ovf(ovf_w[0]));
    uart_tx_fifo #(.CLK_DIV(8), .PARITY(1)) u_b (
        .clk(clk), .rst_n(rst_n_bc), .trmt(trmt[1]), .tx_data(data_b), .TX(tx_w[1]),
        .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_full(full_w[1]),
        .tx_empty(empty_w[1]), .tx_ovf(ovf_w[1]));
    uart_tx_fifo #(.CLK_DIV(8), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n_bc), .trmt(trmt[2]), .tx_data(data_c), .TX(tx_w[2]),
        .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_full(full_w[2]),
        .tx_empty(empty_w[2]), .tx_ovf(ovf_w[2]));

    typedef struct {
        int          d;
        logic [12:0] bits;
        int          gap;   // idle cycles expected before the start bit, -1 = don't care
    } exp_t;
    exp_t sb[$];

    int nchk = 0, nerr = 0;
    int done_cnt_a = 0, ovf_cnt_a = 0;

    always @(negedge clk) begin
        if (done_w[0]) done_cnt_a <= done_cnt_a + 1;
        if (ovf_w[0])  ovf_cnt_a  <= ovf_cnt_a + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decodes frames from one instance: every cycle of each bit must hold the same level.
    task automatic mon(input int d, input int div, input int flen);
        logic [12:0] bits;
        int          bad, gap, idx;
        bit          have, aborted;
        exp_t        e;
        gap  = 0;
        have = 0;
        forever begin
            if (!have) @(negedge clk);
            have = 0;
            if (!rst_w[d])     begin gap = 0; continue; end
            if (tx_w[d] !== 1'b0) begin gap++; continue; end
            bits    = '0;
            bad     = 0;
            aborted = 0;
            for (int i = 0; i < flen * div; i++) begin
                if (i > 0) @(negedge clk);
                if (!rst_w[d]) begin aborted = 1; break; end
                idx = i / div;
                if (i % div == 0) bits[idx] = tx_w[d];
                else if (tx_w[d] !== bits[idx]) bad++;
            end
            if (aborted) begin gap = 0; continue; end
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("unexpected_frame", 32'(bits), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("frame_inst", 32'(d), 32'(e.d));
                chk("frame_bits", 32'(bits), 32'(e.bits));
                chk("bit_hold", 32'(bad), 0);
                chk("done_at_frame_end", 32'(done_w[d]), 1);
                if (e.gap >= 0) chk("frame_gap", 32'(gap), 32'(e.gap));
            end
            gap  = 0;
            have = 1;
        end
    endtask

    initial mon(0, 16, 10);
    initial mon(1, 8, 11);
    initial mon(2, 8, 12);

    // Called just after a rising edge; the word is pushed on the next edge.
    task automatic push(input int d, input logic [7:0] v);
        case (d)
            0: data_a = v;
            1: data_b = v;
            default: data_c = v;
        endcase
        trmt[d] = 1'b1;
        @(posedge clk); #1;
        trmt[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_w[d] && n < bound);
    endtask

    int n, ndone, dc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_w[0]), 1);
        chk("rst_busy", 32'(busy_w[0]), 0);
        chk("rst_done", 32'(done_w[0]), 0);
        chk("rst_full", 32'(full_w[0]), 0);
        chk("rst_empty", 32'(empty_w[0]), 1);
        chk("rst_ovf", 32'(ovf_w[0]), 0);
        rst_n_a  = 1'b1;
        rst_n_bc = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0xA5: start, A5 LSB first, stop
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'hA5, 1'b0}), gap: -1});
        push(0, 8'hA5);
        chk("a5_tx_before_load", 32'(tx_w[0]), 1);
        chk("a5_empty_after_push", 32'(empty_w[0]), 0);
        @(posedge clk); #1;
        chk("a5_tx_low_after_load", 32'(tx_w[0]), 0);
        chk("a5_busy", 32'(busy_w[0]), 1);
        chk("a5_empty_after_pop", 32'(empty_w[0]), 1);
        wait_done(0, 400, n);
        chk("a5_done_latency", 32'(n), 160);
        chk("a5_busy_falls", 32'(busy_w[0]), 0);
        chk("a5_tx_idle", 32'(tx_w[0]), 1);
        @(posedge clk); #1;
        chk("a5_done_one_cycle", 32'(done_w[0]), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("a5_tx_stays_high", 32'(tx_w[0]), 1);

        // even parity 0x07: three ones -> parity 1
        sb.push_back('{d: 1, bits: 13'({1'b1, 1'b1, 8'h07, 1'b0}), gap: -1});
        push(1, 8'h07);
        wait_done(1, 300, n);
        chk("even_par_latency", 32'(n), 89);
        repeat (10) @(posedge clk);
        #1;

        // odd parity 0x07 with two stop bits
        sb.push_back('{d: 2, bits: 13'({2'b11, 1'b0, 8'h07, 1'b0}), gap: -1});
        push(2, 8'h07);
        wait_done(2, 300, n);
        chk("odd_par_2stop_latency", 32'(n), 97);
        repeat (10) @(posedge clk);
        #1;

        // six back-to-back pushes into a 4-deep FIFO; 0x15 is dropped
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h10, 1'b0}), gap: -1});
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h11, 1'b0}), gap: 0});
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h12, 1'b0}), gap: 0});
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h13, 1'b0}), gap: 0});
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h14, 1'b0}), gap: 0});
        trmt[0] = 1'b1;
        data_a  = 8'h10;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 3) chk("fifo_not_full_4th", 32'(full_w[0]), 0);
            if (i == 4) chk("fifo_full_5th", 32'(full_w[0]), 1);
            if (i == 5) chk("fifo_ovf_pulse", 32'(ovf_w[0]), 1);
            data_a = 8'h11 + 8'(i);
        end
        trmt[0] = 1'b0;
        chk("fifo_empty_low", 32'(empty_w[0]), 0);
        @(posedge clk); #1;
        chk("fifo_ovf_one_cycle", 32'(ovf_w[0]), 0);
        ndone = 0;
        n     = 0;
        while (ndone < 5 && n < 1200) begin
            @(posedge clk); #1;
            n++;
            if (done_w[0]) begin
                ndone++;
                if (ndone == 3) chk("fifo_empty_after_3rd", 32'(empty_w[0]), 0);
                if (ndone == 4) chk("fifo_empty_after_4th", 32'(empty_w[0]), 1);
            end
        end
        chk("fifo_done_count", 32'(ndone), 5);
        chk("fifo_ovf_total", 32'(ovf_cnt_a), 1);
        chk("fifo_drained_busy", 32'(busy_w[0]), 0);
        repeat (10) @(posedge clk);
        #1;

        // push inside the stop bit of a lone frame: zero-gap follow-on
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h3C, 1'b0}), gap: -1});
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h5A, 1'b0}), gap: 0});
        push(0, 8'h3C);
        @(posedge clk); #1;
        repeat (149) @(posedge clk);
        #1;
        push(0, 8'h5A);
        ndone = 0;
        n     = 0;
        while (ndone < 2 && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (done_w[0]) ndone++;
        end
        chk("last_bit_push_dones", 32'(ndone), 2);
        repeat (10) @(posedge clk);
        #1;

        // reset during a data bit with two words still queued
        sb.push_back('{d: 0, bits: 13'({1'b1, 8'h11, 1'b0}), gap: -1});
        trmt[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_a = 8'h11 * 8'(i + 1);
            @(posedge clk); #1;
        end
        trmt[0] = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy_w[0]), 1);
        dc      = done_cnt_a;
        rst_n_a = 1'b0;
        sb.delete();
        #1;
        chk("reset_tx_high", 32'(tx_w[0]), 1);
        chk("reset_busy", 32'(busy_w[0]), 0);
        chk("reset_empty", 32'(empty_w[0]), 1);
        repeat (5) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("reset_no_done", 32'(done_cnt_a), 32'(dc));
        chk("reset_tx_idle", 32'(tx_w[0]), 1);
        chk("reset_stays_empty", 32'(empty_w[0]), 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter used in the digital core.
- Configurable: data width, baud divisor, parity mode and stop-bit count.
- A small transmit FIFO lets the command/telemetry logic queue bytes without waiting for each frame to finish.
- Frames go out back-to-back on TX whenever the FIFO holds data.

Parameters:
CLK_DIV, 2605, clk cycles per bit period (2605 = 115200 baud at 300 MHz-class setting used in core); legal 2..4095
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, transmit FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  push request; tx_data is written when trmt=1 and tx_full=0
tx_data  input  DATA_BITS  word to transmit
TX  output  1  serial line, idle high
tx_busy  output  1  high while a frame is being shifted
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit
tx_full  output  1  FIFO holds FIFO_DEPTH words
tx_empty  output  1  FIFO holds 0 words
tx_ovf  output  1  one-cycle pulse when trmt=1 while tx_full=1 (word dropped)

Behaviour:
- Reset (asynchronous, active-low rst_n; clock clk):
  - TX=1, tx_busy=0, tx_done=0, tx_full=0, tx_empty=1, tx_ovf=0.
  - FIFO pointers/count, baud counter and bit counter are 0; FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately; TX returns high asynchronously.
- Frame format, LSB first: start(0), DATA_BITS data, parity bit if PARITY!=0, STOP_BITS x 1.
  - FRAME_LEN = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
  - Parity bit: even = XOR of data; odd = inverted XOR.
  - Computed when the word is loaded into the shifter.
- FIFO:
  - Push on edge where trmt && !tx_full.
  - Pop on edge where FSM loads the shifter.
  - Simultaneous push and pop: both occur, count unchanged.
  - Push while full is ignored, FIFO unchanged, tx_ovf pulses the next cycle.
  - tx_full/tx_empty are registered from count; they reflect the post-edge state.
- FSM states:
  - IDLE: TX=1, tx_busy=0. If !tx_empty, pop head into shifter, clear counters, go to SHIFT.
  - SHIFT: TX = shifter[0] (registered); tx_busy=1.
    - Baud counter runs 0..CLK_DIV-1.
    - At CLK_DIV-1 the baud counter wraps to 0, the shifter shifts right filling 1, and the bit counter increments.
    - When the bit counter reaches FRAME_LEN-1 and the baud counter reaches CLK_DIV-1, the frame ends:
      - tx_done pulses for one cycle on the following cycle.
      - If the FIFO is non-empty on that edge, pop and load the next frame in the same edge, staying in SHIFT. No idle gap: the next start bit follows the last stop bit directly.
      - Otherwise go to IDLE.
- Timing:
  - Latency: trmt sampled at edge k with FIFO empty and FSM IDLE gives a push at k, load at k+1, and TX low after edge k+1.
  - Each bit is held exactly CLK_DIV cycles.
  - A single frame occupies exactly FRAME_LEN*CLK_DIV cycles of TX.
- Counter widths: baud counter is clog2(CLK_DIV) bits; bit counter is 4 bits. No wrap beyond the stated terminal values.
- tx_data is sampled only on push; later changes do not affect queued words.

Test Plan:
- Defaults except CLK_DIV=16; push 0xA5 once.
  - TX low 1 cycle after the push edge; TX bits, each held 16 cycles = 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once, 160 cycles after load; tx_busy falls with it; TX stays 1 afterwards.
- PARITY=1, CLK_DIV=8; push 0x07.
  - Parity bit 1; frame 0,1,1,1,0,0,0,0,0,1,1; 11*8=88 cycles.
- PARITY=2 rerun with 0x07: parity bit 0. STOP_BITS=2: two stop bits, frame 96 cycles.
- FIFO_DEPTH=4, CLK_DIV=16; trmt high 6 consecutive cycles with 0x10..0x15.
  - First word is popped immediately; tx_full high after the 5th push.
  - 6th word (0x15) dropped with a single tx_ovf pulse.
  - Frames 0x10..0x14 sent contiguously with no idle cycle between stop and next start.
  - 5 tx_done pulses; tx_empty=1 after the 2nd pop... i.e. only when all are drained, which occurs once the 5th frame is loaded.
- Push during the last bit of a frame with the FIFO otherwise empty: the new start bit follows the stop bit with zero gap.
- Assert rst_n=0 mid-data-bit of a frame with 2 words queued.
  - TX=1 immediately; tx_busy=0, tx_empty=1.
  - No tx_done pulse; after release, TX stays high with no frames sent.
